// File: rtl/key_schedule_ctrl.sv
// AES-128 key-schedule controller: sequences an external one-cycle expansion stage
// through 10 rounds and holds the resulting 11 round keys in a readable register file.
module key_schedule_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] cipher_key,
  input  logic         abort,
  output logic [3:0]   ke_round_idx,
  output logic [127:0] ke_in_key,
  input  logic [127:0] ke_out_key,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data,
  output logic         busy,
  output logic         done,
  output logic         keys_valid
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXPAND  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [3:0]   rnd;
  logic [127:0] cur_key;
  logic [127:0] rk [0:NUM_ROUNDS];
  logic         done_q;
  logic         keys_valid_q;

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // register samples pre-edge values, regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start) state_nxt = EXPAND;
        EXPAND:  state_nxt = CAPTURE;
        CAPTURE: state_nxt = (rnd == LAST_RND) ? IDLE : EXPAND;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: the round-key file is reset (and zeroized on abort) on purpose: stale key
  // material must never be readable, so it is not left as uninitialised storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd          <= '0;
      cur_key      <= '0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      for (int i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
    end else if (abort) begin
      rnd          <= '0;
      cur_key      <= '0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      for (int i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            rk[0]        <= cipher_key;
            cur_key      <= cipher_key;
            rnd          <= 4'd1;
            keys_valid_q <= 1'b0;
          end
        end
        CAPTURE: begin
          for (int i = 1; i <= NUM_ROUNDS; i++) begin
            if (rnd == 4'(i)) rk[i] <= ke_out_key;
          end
          cur_key <= ke_out_key;
          if (rnd == LAST_RND) begin
            done_q       <= 1'b1;
            keys_valid_q <= 1'b1;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy         = (state != IDLE);
    ke_round_idx = (state == IDLE) ? 4'd0 : rnd;
    ke_in_key    = cur_key;
    done         = done_q;
    keys_valid   = keys_valid_q;
  end

  // Addresses beyond the last round read as zero.
  always_comb begin
    rk_data = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      if (rk_addr == 4'(i)) rk_data = rk[i];
    end
  end

endmodule

// File: doc/key_schedule_ctrl.md
KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_ROUNDS, default 10, meaning the number of AES-128 expansion rounds; only 10 is supported.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port start  input  1  one-cycle request to expand cipher_key.
REQ-005 The block SHALL have port cipher_key  input  128  the AES-128 key, sampled on the edge that accepts start.
REQ-006 The block SHALL have port abort  input  1  stop any expansion and zeroize all stored round keys.
REQ-007 The block SHALL have port ke_round_idx  output  4  round index driven to the external expansion stage.
REQ-008 The block SHALL have port ke_in_key  output  128  previous round key driven to the external expansion stage.
REQ-009 The block SHALL have port ke_out_key  input  128  the expansion stage's registered result (one-cycle latency).
REQ-010 The block SHALL have port rk_addr  input  4  round-key read address, 0..10.
REQ-011 The block SHALL have port rk_data  output  128  round key at rk_addr.
REQ-012 The block SHALL have port busy  output  1  high while expansion is in progress.
REQ-013 The block SHALL have port done  output  1  one-cycle pulse when all 11 round keys are stored.
REQ-014 The block SHALL have port keys_valid  output  1  high while the stored key set is complete and usable.

Function
REQ-015 The FSM SHALL have states IDLE, EXPAND and CAPTURE, plus a 4-bit round counter rnd and an 11x128 round-key register file rk[0..10].
REQ-016 In IDLE with start=1 and abort=0: rk[0]<=cipher_key, cur_key<=cipher_key, rnd<=1, keys_valid<=0, next state EXPAND.
REQ-017 ke_in_key SHALL equal cur_key; ke_round_idx SHALL equal rnd in EXPAND/CAPTURE and 0 in IDLE.
REQ-018 EXPAND SHALL last exactly one cycle, during which the stage registers its result, and SHALL be followed by CAPTURE.
REQ-019 CAPTURE: rk[rnd]<=ke_out_key and cur_key<=ke_out_key; if rnd==10, go IDLE, pulse done, set keys_valid; else rnd<=rnd+1 and go EXPAND.
REQ-020 Latency: with start accepted at edge E0, round r SHALL be written at edge E(2r), and rk[10] at E20; done SHALL be high for exactly the cycle following E20.
REQ-021 busy SHALL be high exactly when state != IDLE (cycles E0..E20).
REQ-022 start while busy SHALL be ignored, with no effect on the state, the counter or the stored keys.
REQ-023 abort=1 in any state SHALL, on the next edge: go IDLE, set rnd=0, clear cur_key and all rk entries to 0, clear keys_valid, and suppress done.
REQ-024 abort and start in the same cycle: abort SHALL win; start is dropped.
REQ-025 rk_data SHALL be combinational: rk[rk_addr] if rk_addr<=10, else 128'h0; reads SHALL be permitted at any time, including mid-expansion (partial keys).
REQ-026 A new start in IDLE with keys_valid=1 SHALL clear keys_valid on the accepting edge and overwrite keys round by round.
REQ-027 rnd SHALL never exceed 10 and SHALL never wrap.

Reset
REQ-028 On rst_n=0, asynchronously: state IDLE, rnd=0, cur_key=0, all rk=0, busy=0, done=0, keys_valid=0, ke_round_idx=0, ke_in_key=0.
REQ-029 Reset asserted mid-expansion SHALL discard all progress, and no done pulse SHALL follow its release.

Verification
REQ-030 The bench SHALL cover FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start -> done at cycle 21, rk[1]=a0fafe1788542cb123a339392a6c7605, rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6, keys_valid=1.
REQ-031 The bench SHALL cover start again at cycle 5 of an expansion -> ignored; the final keys match the first key only; exactly one done.
REQ-032 The bench SHALL cover abort at cycle 9 -> next cycle busy=0, all rk_data=0 for addr 0..10, keys_valid=0, and no done.
REQ-033 The bench SHALL cover start+abort in the same cycle from IDLE -> stays IDLE, busy=0, rk all zero.
REQ-034 The bench SHALL cover rk_addr=11..15 -> rk_data=0; rst_n pulsed low at cycle 12 -> all outputs 0 immediately, and no done afterward.
REQ-035 The bench SHALL cover back-to-back keys (all-zero key, then the FIPS key) -> rk[10] for the zero key is b4ef5bcb3e92e21123e951cf6f8f188e, keys_valid drops on the second start, and the second set is correct.
